muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_step.sv | 35 +++
 rtl/muldiv_seq.sv | 155 +++++++++++++++
 tb/tb_muldiv_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential HI/LO multiply/divide unit.
// The optional divider is built only when MULDIV_SEQ_DIV_EN is defined.
package muldiv_pkg;

  localparam int ITERATIONS = 32;
  localparam int W = 32;

  typedef enum logic [1:0] {
    MULT  = 2'd0,
    MULTU = 2'd1,
    DIV   = 2'd2,
    DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_e;

  function automatic logic [W-1:0] mag(
    input logic [W-1:0] x,
    input logic         s
  );
    return s ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring shift-subtract divide.
// Divide path is present only when MULDIV_SEQ_DIV_EN is defined.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic [2*W-1:0] acc_i,
  input  logic [W-1:0]   m_i,
`ifdef MULDIV_SEQ_DIV_EN
  input  logic           div_i,
`endif
  output logic [2*W-1:0] acc_o
);

  logic [W:0] sum;
`ifdef MULDIV_SEQ_DIV_EN
  logic [W:0] diff;
`endif

  always_comb begin
    sum   = {1'b0, acc_i[2*W-1:W]}
          + (acc_i[0] ? {1'b0, m_i} : '0);
    acc_o = {sum, acc_i[W-1:1]};
`ifdef MULDIV_SEQ_DIV_EN
    diff = acc_i[2*W-1:W-1] - {1'b0, m_i};
    if (div_i) begin
      // Upper half is the partial remainder, lower half collects quotient bits.
      if (!diff[W])
        acc_o = {diff[W-1:0], acc_i[W-2:0], 1'b1};
      else
        acc_o = {acc_i[2*W-2:0], 1'b0};
    end
`endif
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative HI/LO multiply/divide unit with MTHI/MTLO writes.
// Define MULDIV_SEQ_DIV_EN to build the divider; otherwise DIV/DIVU are no-ops.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e             state_q;
  logic [4:0]         cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] acc_init;
  logic [WIDTH-1:0]   m_q;
  logic [WIDTH-1:0]   m_init;
  logic               neg_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic [2*WIDTH-1:0] prod;
  logic               busy_q, done_q;
  logic               sa, sb;
`ifdef MULDIV_SEQ_DIV_EN
  logic               div_q;
  logic               divz_q;
  logic               negr_q;
  logic [WIDTH-1:0]   a_q;
`endif

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  assign sa = a[WIDTH-1] & ~op[0];
  assign sb = b[WIDTH-1] & ~op[0];

  always_comb begin
    acc_init = {{WIDTH{1'b0}}, mag(b, sb)};
    m_init   = mag(a, sa);
`ifdef MULDIV_SEQ_DIV_EN
    if (op[1]) begin
      acc_init = {{WIDTH{1'b0}}, mag(a, sa)};
      m_init   = mag(b, sb);
    end
`endif
  end

  muldiv_step u_step (
    .acc_i (acc_q),
    .m_i   (m_q),
`ifdef MULDIV_SEQ_DIV_EN
    .div_i (div_q),
`endif
    .acc_o (acc_d)
  );

  always_comb begin
    prod   = neg_q ? (~acc_q + 1'b1) : acc_q;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
`ifdef MULDIV_SEQ_DIV_EN
    if (div_q) begin
      if (divz_q) begin
        res_hi = a_q;
        res_lo = '1;
      end else begin
        res_hi = mag(acc_q[2*WIDTH-1:WIDTH], negr_q);
        res_lo = mag(acc_q[WIDTH-1:0], neg_q);
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MULDIV_SEQ_DIV_EN
      div_q   <= 1'b0;
      divz_q  <= 1'b0;
      negr_q  <= 1'b0;
      a_q     <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hi_wr) hi_q <= wr_data;
          if (lo_wr) lo_q <= wr_data;
          if (start) begin
            acc_q  <= acc_init;
            m_q    <= m_init;
            neg_q  <= sa ^ sb;
            cnt_q  <= '0;
            busy_q <= 1'b1;
`ifdef MULDIV_SEQ_DIV_EN
            div_q   <= op[1];
            divz_q  <= (b == '0);
            negr_q  <= sa;
            a_q     <= a;
            state_q <= RUN;
`else
            if (op[1]) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
            end
`endif
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'(ITERATIONS - 1))
            state_q <= FIX;
        end
        FIX: begin
          // Result lands together with done so hi/lo are valid in DONE.
          hi_q    <= res_hi;
          lo_q    <= res_lo;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed-vector bench for muldiv_seq; DIV expectations follow
// whether MULDIV_SEQ_DIV_EN is defined.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        hi_wr, lo_wr;
  logic [31:0] wr_data;
  logic        busy, done;
  logic [31:0] hi, lo;

  int nvec = 0;
  int nerr = 0;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .hi_wr   (hi_wr),
    .lo_wr   (lo_wr),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  // Called in the low phase; returns at the negedge where done is seen.
  task automatic run_op(
    input  logic [1:0]  o,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output int          lat
  );
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      if (done) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
    hi_wr = 1'b0; lo_wr = 1'b0; wr_data = '0;
    #2;
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b exp 0", busy); end
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done got %b exp 0", done); end
    nvec++; if (hi !== 32'h0) begin nerr++; $display("FAIL reset_hi got %h exp 0", hi); end
    nvec++; if (lo !== 32'h0) begin nerr++; $display("FAIL reset_lo got %h exp 0", lo); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mult;
    int lat;
    run_op(MULTU, 32'hFFFFFFFF, 32'h2, lat);
    nvec++; if (lat !== 34) begin nerr++; $display("FAIL multu_lat got %0d exp 34", lat); end
    nvec++; if (hi !== 32'h1) begin nerr++; $display("FAIL multu_hi got %h exp 00000001", hi); end
    nvec++; if (lo !== 32'hFFFFFFFE) begin nerr++; $display("FAIL multu_lo got %h exp fffffffe", lo); end
    @(negedge clk);
    run_op(MULT, 32'hFFFFFFFD, 32'h5, lat);
    nvec++; if (hi !== 32'hFFFFFFFF) begin nerr++; $display("FAIL mult_neg_hi got %h exp ffffffff", hi); end
    nvec++; if (lo !== 32'hFFFFFFF1) begin nerr++; $display("FAIL mult_neg_lo got %h exp fffffff1", lo); end
    @(negedge clk);
    run_op(MULT, 32'h80000000, 32'h80000000, lat);
    nvec++; if (hi !== 32'h40000000) begin nerr++; $display("FAIL mult_min_hi got %h exp 40000000", hi); end
    nvec++; if (lo !== 32'h0) begin nerr++; $display("FAIL mult_min_lo got %h exp 00000000", lo); end
    @(negedge clk);
    run_op(MULT, 32'h7, 32'hFFFFFFFF, lat);
    nvec++; if (hi !== 32'hFFFFFFFF) begin nerr++; $display("FAIL mult_m1_hi got %h exp ffffffff", hi); end
    nvec++; if (lo !== 32'hFFFFFFF9) begin nerr++; $display("FAIL mult_m1_lo got %h exp fffffff9", lo); end
    @(negedge clk);
    run_op(MULTU, 32'h00010000, 32'h00010000, lat);
    nvec++; if (hi !== 32'h1) begin nerr++; $display("FAIL multu_sq_hi got %h exp 00000001", hi); end
    nvec++; if (lo !== 32'h0) begin nerr++; $display("FAIL multu_sq_lo got %h exp 00000000", lo); end
    @(negedge clk);
  endtask

  task automatic test_div;
    int lat;
`ifdef MULDIV_SEQ_DIV_EN
    run_op(DIV, 32'hFFFFFFF9, 32'h2, lat);
    nvec++; if (lat !== 34) begin nerr++; $display("FAIL div_lat got %0d exp 34", lat); end
    nvec++; if (lo !== 32'hFFFFFFFD) begin nerr++; $display("FAIL div_neg_lo got %h exp fffffffd", lo); end
    nvec++; if (hi !== 32'hFFFFFFFF) begin nerr++; $display("FAIL div_neg_hi got %h exp ffffffff", hi); end
    @(negedge clk);
    run_op(DIVU, 32'd100, 32'd7, lat);
    nvec++; if (lo !== 32'hE) begin nerr++; $display("FAIL divu_lo got %h exp 0000000e", lo); end
    nvec++; if (hi !== 32'h2) begin nerr++; $display("FAIL divu_hi got %h exp 00000002", hi); end
    @(negedge clk);
    run_op(DIV, 32'h80000000, 32'hFFFFFFFF, lat);
    nvec++; if (lo !== 32'h80000000) begin nerr++; $display("FAIL div_ovf_lo got %h exp 80000000", lo); end
    nvec++; if (hi !== 32'h0) begin nerr++; $display("FAIL div_ovf_hi got %h exp 00000000", hi); end
    @(negedge clk);
    run_op(DIVU, 32'd100, 32'h0, lat);
    nvec++; if (lat !== 34) begin nerr++; $display("FAIL divz_lat got %0d exp 34", lat); end
    nvec++; if (hi !== 32'h64) begin nerr++; $display("FAIL divz_hi got %h exp 00000064", hi); end
    nvec++; if (lo !== 32'hFFFFFFFF) begin nerr++; $display("FAIL divz_lo got %h exp ffffffff", lo); end
    @(negedge clk);
    run_op(DIV, 32'hFFFFFF9C, 32'h0, lat);
    nvec++; if (hi !== 32'hFFFFFF9C) begin nerr++; $display("FAIL divz_s_hi got %h exp ffffff9c", hi); end
    nvec++; if (lo !== 32'hFFFFFFFF) begin nerr++; $display("FAIL divz_s_lo got %h exp ffffffff", lo); end
    @(negedge clk);
`else
    hi_wr = 1'b1; lo_wr = 1'b1; wr_data = 32'h1111;
    @(negedge clk);
    hi_wr = 1'b0; lo_wr = 1'b0;
    run_op(DIV, 32'hFFFFFFF9, 32'h2, lat);
    nvec++; if (lat !== 1) begin nerr++; $display("FAIL nodiv_lat got %0d exp 1", lat); end
    nvec++; if (hi !== 32'h1111) begin nerr++; $display("FAIL nodiv_hi got %h exp 00001111", hi); end
    nvec++; if (lo !== 32'h1111) begin nerr++; $display("FAIL nodiv_lo got %h exp 00001111", lo); end
    @(negedge clk);
    run_op(DIVU, 32'd100, 32'h0, lat);
    nvec++; if (lat !== 1) begin nerr++; $display("FAIL nodivu_lat got %0d exp 1", lat); end
    nvec++; if (hi !== 32'h1111) begin nerr++; $display("FAIL nodivu_hi got %h exp 00001111", hi); end
    @(negedge clk);
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL nodiv_idle got %b exp 0", busy); end
`endif
  endtask

  task automatic test_back_to_back;
    int lat;
    run_op(MULTU, 32'd6, 32'd7, lat);
    @(negedge clk);
    run_op(MULTU, 32'd9, 32'd9, lat);
    nvec++; if (lat !== 34) begin nerr++; $display("FAIL b2b_lat got %0d exp 34", lat); end
    nvec++; if (lo !== 32'd81) begin nerr++; $display("FAIL b2b_lo got %h exp 00000051", lo); end
    @(negedge clk);
  endtask

  task automatic test_busy_start;
    int ndone;
    int first;
    logic [31:0] rhi, rlo;
    ndone = 0; first = -1; rhi = '0; rlo = '0;
    start = 1'b1; op = MULTU; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0; a = 32'd5; b = 32'd5;
    for (int c = 1; c <= 70; c++) begin
      if (done) begin
        ndone++;
        if (first < 0) begin
          first = c; rhi = hi; rlo = lo;
        end
      end
      start = (c == 10);
      @(negedge clk);
    end
    start = 1'b0;
    nvec++; if (ndone !== 1) begin nerr++; $display("FAIL busy_ndone got %0d exp 1", ndone); end
    nvec++; if (first !== 34) begin nerr++; $display("FAIL busy_lat got %0d exp 34", first); end
    nvec++; if (rlo !== 32'hC) begin nerr++; $display("FAIL busy_lo got %h exp 0000000c", rlo); end
    nvec++; if (rhi !== 32'h0) begin nerr++; $display("FAIL busy_hi got %h exp 00000000", rhi); end
  endtask

  task automatic test_reset_mid;
    int lat;
    hi_wr = 1'b1; lo_wr = 1'b1; wr_data = 32'h1234;
    @(negedge clk);
    hi_wr = 1'b0; lo_wr = 1'b0;
    nvec++; if (hi !== 32'h1234) begin nerr++; $display("FAIL pre_hi got %h exp 00001234", hi); end
    start = 1'b1; op = MULT; a = 32'd7; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    #1;
    nvec++; if (hi !== 32'h0) begin nerr++; $display("FAIL rmid_hi got %h exp 0", hi); end
    nvec++; if (lo !== 32'h0) begin nerr++; $display("FAIL rmid_lo got %h exp 0", lo); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rmid_busy got %b exp 0", busy); end
    @(negedge clk);
    reset = 1'b0;
    run_op(MULT, 32'd7, 32'd9, lat);
    nvec++; if (lat !== 34) begin nerr++; $display("FAIL rmid_lat got %0d exp 34", lat); end
    nvec++; if (lo !== 32'h3F) begin nerr++; $display("FAIL rmid_lo2 got %h exp 0000003f", lo); end
    @(negedge clk);
  endtask

  task automatic test_hilo_wr;
    int c;
    start = 1'b1; op = MULTU; a = 32'd2; b = 32'd3;
    hi_wr = 1'b1; wr_data = 32'hABCD;
    @(negedge clk);
    start = 1'b0; hi_wr = 1'b0;
    nvec++; if (hi !== 32'hABCD) begin nerr++; $display("FAIL wr_start_hi got %h exp 0000abcd", hi); end
    hi_wr = 1'b1; lo_wr = 1'b1; wr_data = 32'h5555;
    @(negedge clk);
    hi_wr = 1'b0; lo_wr = 1'b0;
    nvec++; if (hi !== 32'hABCD) begin nerr++; $display("FAIL wr_busy_hi got %h exp 0000abcd", hi); end
    c = 2;
    while (!done && c < 60) begin
      @(negedge clk);
      c++;
    end
    nvec++; if (c !== 34) begin nerr++; $display("FAIL wr_lat got %0d exp 34", c); end
    nvec++; if (hi !== 32'h0) begin nerr++; $display("FAIL wr_res_hi got %h exp 00000000", hi); end
    nvec++; if (lo !== 32'h6) begin nerr++; $display("FAIL wr_res_lo got %h exp 00000006", lo); end
    @(negedge clk);
    hi_wr = 1'b1; wr_data = 32'hABCD;
    @(negedge clk);
    hi_wr = 1'b0;
    nvec++; if (hi !== 32'hABCD) begin nerr++; $display("FAIL wr_idle_hi got %h exp 0000abcd", hi); end
    nvec++; if (lo !== 32'h6) begin nerr++; $display("FAIL wr_idle_lo got %h exp 00000006", lo); end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_back_to_back;
    test_busy_start;
    test_reset_mid;
    test_hilo_wr;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
